// File: rtl/add_stim_chk_pkg.sv
// Shared types and helpers for the adder stimulus/checker block.
// Holds the FSM state type, LFSR definition and a saturating 16-bit add.
package add_stim_pkg;

   localparam int DW_DEF = 8;
   localparam int RW     = DW_DEF + 1;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/add_stim_chk_if.sv
// Valid-qualified adder bus: operands toward the adder, sum back.
// master = traffic source/checker, slave = adder.
interface add_stim_chk_if #(
   parameter int DW = 8
);
   logic          din_vld;
   logic [DW-1:0] din_a;
   logic [DW-1:0] din_b;
   logic          dout_vld;
   logic [DW:0]   dout;

   modport master (output din_vld, din_a, din_b, input dout_vld, dout);
   modport slave  (input din_vld, din_a, din_b, output dout_vld, dout);
endinterface

// File: rtl/add_stim_chk_sync_fifo.sv
// Small synchronous FIFO holding expected sums in issue order.
// Pointers carry an extra wrap bit so full and empty stay distinct.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      srst,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  logic [WIDTH-1:0]          din,
   output logic [WIDTH-1:0]          dout,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;
   logic             do_push;
   logic             do_pop;

   assign count   = wptr_q - rptr_q;
   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head is read combinationally so it can be compared in the pop cycle
   assign dout = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (do_pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/add_stim_chk.sv
// LFSR traffic source and in-order result checker for an 8-bit adder.
// Issues NUM_VEC operand pairs, compares each returned sum, reports pass/fail.
module add_stim_chk
   import add_stim_pkg::*;
#(
   parameter int          DW         = DW_DEF,
   parameter int          NUM_VEC    = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] SEED       = 16'hFF01,
   parameter int          TIMEOUT    = 64
) (
   input  logic          clk,
   input  logic          rst_in,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [15:0]   err_cnt,
   output logic [15:0]   vec_cnt,
   output logic          unexp,
   add_stim_chk_if.master bus
);
   localparam int RES_W = DW + 1;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam logic [15:0]   NUM_VEC_C = 16'(NUM_VEC);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [15:0]     lfsr_q, lfsr_d;
   logic [15:0]     issued_q, issued_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [15:0]     err_q, err_d;
   logic [15:0]     vec_q, vec_d;
   logic            unexp_q, unexp_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            din_vld_q, din_vld_d;
   logic [DW-1:0]   din_a_q, din_a_d;
   logic [DW-1:0]   din_b_q, din_b_d;

   logic            busy_w;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_flush;
   logic [RES_W-1:0] fifo_din;
   logic [RES_W-1:0] fifo_head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;

   sync_fifo #(
      .WIDTH (RES_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .srst  (rst_in),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (fifo_din),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign busy_w = (state_q == RUN) || (state_q == DRAIN);

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      issued_d   = issued_q;
      tmo_d      = tmo_q;
      err_d      = err_q;
      vec_d      = vec_q;
      unexp_d    = unexp_q;
      done_d     = done_q;
      pass_d     = pass_q;
      din_vld_d  = 1'b0;
      din_a_d    = din_a_q;
      din_b_d    = din_b_q;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      fifo_din   = RES_W'(lfsr_q[DW-1:0]) + RES_W'(lfsr_q[2*DW-1:DW]);

      // Result check runs in both RUN and DRAIN
      if (busy_w && bus.dout_vld) begin
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            vec_d    = vec_q + 16'd1;
            if (bus.dout != fifo_head) begin
               err_d = sat_add16(err_q, 16'd1);
            end
         end else begin
            err_d   = sat_add16(err_q, 16'd1);
            unexp_d = 1'b1;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               lfsr_d     = SEED;
               issued_d   = '0;
               tmo_d      = '0;
               err_d      = '0;
               vec_d      = '0;
               unexp_d    = 1'b0;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               fifo_flush = 1'b1;
            end
         end
         RUN: begin
            if (issued_q == NUM_VEC_C) begin
               state_d = DRAIN;
            end else if (!fifo_full) begin
               din_vld_d = 1'b1;
               din_a_d   = lfsr_q[DW-1:0];
               din_b_d   = lfsr_q[2*DW-1:DW];
               lfsr_d    = lfsr_next(lfsr_q);
               issued_d  = issued_q + 16'd1;
               fifo_push = 1'b1;
            end
         end
         DRAIN: begin
            tmo_d = bus.dout_vld ? '0 : tmo_q + 1'b1;
            if (fifo_empty) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == 16'd0);
            end else if (!bus.dout_vld && (tmo_q == TMO_LAST)) begin
               // Every vector still outstanding counts as a missing result
               err_d      = sat_add16(err_q, 16'(fifo_count));
               fifo_flush = 1'b1;
               state_d    = DONE;
               done_d     = 1'b1;
               pass_d     = (err_d == 16'd0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q   <= IDLE;
         lfsr_q    <= SEED;
         issued_q  <= '0;
         tmo_q     <= '0;
         err_q     <= '0;
         vec_q     <= '0;
         unexp_q   <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         din_vld_q <= 1'b0;
         din_a_q   <= '0;
         din_b_q   <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         issued_q  <= issued_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         vec_q     <= vec_d;
         unexp_q   <= unexp_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         din_vld_q <= din_vld_d;
         din_a_q   <= din_a_d;
         din_b_q   <= din_b_d;
      end
   end

   assign busy        = busy_w;
   assign done        = done_q;
   assign pass        = pass_q;
   assign err_cnt     = err_q;
   assign vec_cnt     = vec_q;
   assign unexp       = unexp_q;
   assign bus.din_vld = din_vld_q;
   assign bus.din_a   = din_a_q;
   assign bus.din_b   = din_b_q;

endmodule

// File: tb/tb_add_stim_chk.sv
// Bench for add_stim_chk: two instances (FIFO depth 4 and 8), each with a
// behavioural adder responder, operand model and final-count checks.
module tb_add_stim_chk;
   localparam int          NV   = 16;
   localparam int          TMO  = 64;
   localparam int          TRW  = add_stim_pkg::RW;
   localparam logic [15:0] SEED = 16'hFF01;

   logic            clk = 1'b0;
   logic            rst_in;
   logic [1:0]      start;
   logic [1:0]      busy, done, pass, unexp;
   logic [1:0][15:0] err_cnt, vec_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat = 1, corrupt_n = 0, max_ret = NV, inject_cyc = -1, sel = 0;
   int n_iss[2], n_ret[2], n_rx[2], stalls[2];
   logic [15:0] m_lfsr[2];
   logic [7:0]  first_a[2], first_b[2], second_a[2], second_b[2];

   add_stim_chk_if #(.DW(8)) bus [2] ();

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] tb_lfsr(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_u
      localparam int DEPTH = (gi == 0) ? 4 : 8;
      logic [TRW-1:0] rsp_q[$];
      int             rdy_q[$];

      add_stim_chk #(
         .DW(8), .NUM_VEC(NV), .FIFO_DEPTH(DEPTH), .SEED(SEED), .TIMEOUT(TMO)
      ) u_dut (
         .clk(clk), .rst_in(rst_in), .start(start[gi]), .busy(busy[gi]),
         .done(done[gi]), .pass(pass[gi]), .err_cnt(err_cnt[gi]),
         .vec_cnt(vec_cnt[gi]), .unexp(unexp[gi]), .bus(bus[gi])
      );

      // Monitor first (operands, outstanding bound), then the adder responder
      initial begin
         logic [TRW-1:0] s;
         bus[gi].dout_vld = 1'b0;
         bus[gi].dout     = '0;
         forever begin
            @(negedge clk);
            bus[gi].dout_vld = 1'b0;
            if (rst_in) begin
               rsp_q.delete();
               rdy_q.delete();
            end else begin
               if (bus[gi].din_vld) begin
                  n_iss[gi]++;
                  chk("operands", 32'({bus[gi].din_b, bus[gi].din_a}), 32'(m_lfsr[gi]));
                  if (n_iss[gi] == 1) begin
                     first_a[gi] = bus[gi].din_a;
                     first_b[gi] = bus[gi].din_b;
                  end
                  if (n_iss[gi] == 2) begin
                     second_a[gi] = bus[gi].din_a;
                     second_b[gi] = bus[gi].din_b;
                  end
                  m_lfsr[gi] = tb_lfsr(m_lfsr[gi]);
                  chk("outstanding_le_depth", 32'((n_iss[gi] - n_ret[gi]) <= DEPTH), 32'd1);
               end else if (busy[gi] && n_iss[gi] < NV) begin
                  stalls[gi]++;
               end
               if (rdy_q.size() > 0 && rdy_q[0] <= cyc) begin
                  s = rsp_q.pop_front();
                  void'(rdy_q.pop_front());
                  n_rx[gi]++;
                  if (n_rx[gi] <= max_ret) begin
                     if (n_rx[gi] == corrupt_n) s = s ^ 9'd1;
                     bus[gi].dout_vld = 1'b1;
                     bus[gi].dout     = s;
                     n_ret[gi]++;
                  end
               end
               if (sel == gi && inject_cyc == cyc) begin
                  bus[gi].dout_vld = 1'b1;
                  bus[gi].dout     = '0;
               end
               if (bus[gi].din_vld) begin
                  rsp_q.push_back(TRW'(bus[gi].din_a) + TRW'(bus[gi].din_b));
                  rdy_q.push_back(cyc + lat);
               end
            end
         end
      end
   end

   task automatic run_case(input string nm, input int u, input int l, input int cn,
                           input int mr, input bit inj, input int e_err, input int e_vec,
                           input bit e_unexp, input int bound, output int done_lat);
      int t0;
      int waited;
      sel = u; lat = l; corrupt_n = cn; max_ret = mr;
      n_iss[u] = 0; n_ret[u] = 0; n_rx[u] = 0; stalls[u] = 0; m_lfsr[u] = SEED;
      @(negedge clk);
      start[u]   = 1'b1;
      t0         = cyc;
      inject_cyc = inj ? cyc + 1 : -1;
      @(negedge clk);
      start[u] = 1'b0;
      waited   = 1;
      while (!done[u] && waited < bound) begin
         @(negedge clk);
         waited++;
      end
      done_lat   = cyc - t0;
      inject_cyc = -1;
      chk({nm, "_done"},    32'(done[u]),    32'd1);
      chk({nm, "_busy"},    32'(busy[u]),    32'd0);
      chk({nm, "_err_cnt"}, 32'(err_cnt[u]), 32'(e_err));
      chk({nm, "_vec_cnt"}, 32'(vec_cnt[u]), 32'(e_vec));
      chk({nm, "_pass"},    32'(pass[u]),    32'(e_err == 0));
      chk({nm, "_unexp"},   32'(unexp[u]),   32'(e_unexp));
      $display("case %s: err_cnt=%0d vec_cnt=%0d pass=%0d unexp=%0d cycles=%0d",
               nm, err_cnt[u], vec_cnt[u], pass[u], unexp[u], done_lat);
   endtask

   initial begin
      int l;
      rst_in = 1'b1;
      start  = '0;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_busy",    32'(busy[u]),        32'd0);
         chk("rst_done",    32'(done[u]),        32'd0);
         chk("rst_pass",    32'(pass[u]),        32'd0);
         chk("rst_err_cnt", 32'(err_cnt[u]),     32'd0);
         chk("rst_vec_cnt", 32'(vec_cnt[u]),     32'd0);
         chk("rst_unexp",   32'(unexp[u]),       32'd0);
      end
      chk("rst_din_vld", 32'(bus[0].din_vld), 32'd0);
      chk("rst_din_a",   32'(bus[0].din_a),   32'd0);
      chk("rst_din_b",   32'(bus[0].din_b),   32'd0);
      rst_in = 1'b0;
      @(negedge clk);

      run_case("loopback", 0, 1, 0, NV, 1'b0, 0, NV, 1'b0, 40, l);
      chk("loopback_within_40", 32'(l <= 40), 32'd1);
      chk("first_din_a",  32'(first_a[0]),  32'h01);
      chk("first_din_b",  32'(first_b[0]),  32'hFF);
      chk("second_din_a", 32'(second_a[0]), 32'h02);
      chk("second_din_b", 32'(second_b[0]), 32'hFE);

      run_case("corrupt3", 0, 1, 3, NV, 1'b0, 1, NV, 1'b0, 100, l);

      run_case("lat6", 0, 6, 0, NV, 1'b0, 0, NV, 1'b0, 300, l);
      chk("lat6_stalled", 32'(stalls[0] >= 8), 32'd1);
      chk("lat6_issued",  32'(n_iss[0]),       32'(NV));

      run_case("timeout", 1, 1, 0, 10, 1'b0, 6, 10, 1'b0, 300, l);
      chk("timeout_latency", 32'(l >= TMO + 16 && l <= TMO + 20), 32'd1);

      run_case("unexp", 0, 1, 0, NV, 1'b1, 1, NV, 1'b1, 100, l);

      // Abort a run that already has one error, then confirm a clean restart
      sel = 0; lat = 1; corrupt_n = 3; max_ret = NV;
      n_iss[0] = 0; n_ret[0] = 0; n_rx[0] = 0; m_lfsr[0] = SEED;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (8) @(negedge clk);
      chk("midrun_busy",    32'(busy[0]),    32'd1);
      chk("midrun_err_cnt", 32'(err_cnt[0]), 32'd1);
      rst_in = 1'b1;
      @(negedge clk);
      chk("midrst_busy",    32'(busy[0]),        32'd0);
      chk("midrst_done",    32'(done[0]),        32'd0);
      chk("midrst_pass",    32'(pass[0]),        32'd0);
      chk("midrst_err_cnt", 32'(err_cnt[0]),     32'd0);
      chk("midrst_vec_cnt", 32'(vec_cnt[0]),     32'd0);
      chk("midrst_unexp",   32'(unexp[0]),       32'd0);
      chk("midrst_din_vld", 32'(bus[0].din_vld), 32'd0);
      chk("midrst_din_a",   32'(bus[0].din_a),   32'd0);
      chk("midrst_din_b",   32'(bus[0].din_b),   32'd0);
      $display("case midrun_reset: busy=%0d err_cnt=%0d vec_cnt=%0d", busy[0], err_cnt[0], vec_cnt[0]);
      @(negedge clk);
      rst_in = 1'b0;
      @(negedge clk);

      run_case("after_rst", 0, 1, 0, NV, 1'b0, 0, NV, 1'b0, 40, l);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add_stim_chk.md
Name: add_stim_chk

Overview:
- Self-checking traffic source and result sink for the 8-bit valid-qualified adder interface (din_vld/din_a/din_b in, dout_vld/dout[8:0] out).
- Drives the operand side with a deterministic LFSR sequence and keeps expected sums in a small in-order FIFO.
- Compares every returned result and reports pass/fail with error and vector counts.
- Sits beside the adder in the block-level test top and also serves as a built-in self-test.

Parameters:
- DW, 8: operand width; result width is DW+1.
- NUM_VEC, 16: vectors issued per run (1..65535).
- FIFO_DEPTH, 4: maximum outstanding vectors; power of 2, at least 2.
- SEED, 16'hFF01: LFSR seed, reloaded on every start.
- TIMEOUT, 64: drain-phase timeout in cycles.

Ports:
- clk  in  1  system clock
- rst_in  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a run when the FSM is in IDLE or DONE
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- pass  out  1  valid when done=1; equals (err_cnt==0)
- err_cnt  out  16  error count, saturating at 16'hFFFF
- vec_cnt  out  16  number of results checked
- unexp  out  1  sticky: a result arrived with no vector outstanding
- din_vld  out  1  operand valid
- din_a  out  DW  operand a
- din_b  out  DW  operand b
- dout_vld  in  1  result valid
- dout  in  DW+1  result

Behaviour:
- Reset (rst_in=1 at a clk edge):
  - FSM goes to IDLE; FIFO is emptied; LFSR loads SEED.
  - All outputs return 0: din_vld, din_a, din_b, busy, done, pass, err_cnt, vec_cnt, unexp.
  - Reset mid-run aborts with no report.
- FSM states:
  - IDLE: start -> RUN.
  - RUN: when issued==NUM_VEC, go to DRAIN.
  - DRAIN: FIFO empty -> DONE; timeout counter reaches TIMEOUT -> DONE.
  - DONE: start -> RUN.
- Entering RUN clears err_cnt, vec_cnt, unexp, the issued counter and the timeout counter, and reloads the LFSR with SEED.
- Issue (registered outputs):
  - In RUN, when issued<NUM_VEC and the FIFO is not full, assert din_vld for one cycle.
  - Operands: din_a=lfsr[7:0], din_b=lfsr[15:8]; the LFSR advances only on an issue cycle.
  - First vector = SEED unmodified.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  - The full check ignores a pop in the same cycle (conservative, with one cycle of bubble).
  - Issues back-to-back every cycle while not full.
  - din_a and din_b hold their last values when din_vld=0.
- Expected value:
  - On issue, push zero-extended din_a + din_b ((DW+1) bits) into the FIFO in the same cycle.
- Check:
  - A dout_vld cycle while busy with the FIFO non-empty pops the FIFO, increments vec_cnt, and adds 1 to err_cnt if dout != head.
  - A dout_vld cycle while busy with the FIFO empty adds 1 to err_cnt and sets unexp.
  - dout_vld is ignored in IDLE and DONE.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- Latency independence: any responder latency of 1 cycle or more and any gaps are tolerated; ordering must be in-order.
- Timeout:
  - The counter increments each DRAIN cycle with no dout_vld and clears on dout_vld.
  - On reaching TIMEOUT, add the FIFO occupancy to err_cnt (saturating), flush the FIFO, and go to DONE.
- done and pass are updated on the cycle of entry to DONE and held until start or reset.
- start while busy is ignored.

Decomposition:
- Package add_stim_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - LFSR tap constant
  - function lfsr_next()
  - localparam RW = DW+1
- Sub-module: sync_fifo, parameterised (WIDTH, DEPTH).
  - Ports: push, pop, din, dout, full, empty, count.
  - Synchronous active-high reset.
  - Pointers are one bit wider than the address, giving full/empty detection at wrap-around.

Test Plan:
- Loopback with a correct 1-cycle adder, NUM_VEC=16 -> done within 40 cycles of start; vec_cnt=16, err_cnt=0, pass=1, unexp=0.
- SEED=16'hFF01, first issue -> din_a=8'h01, din_b=8'hFF; responder returns 9'h100 -> no error (carry bit checked).
- Responder XORs 1 into the 3rd result -> err_cnt=1, pass=0, vec_cnt=16.
- Responder latency 6 cycles, FIFO_DEPTH=4:
  - Never more than 4 outstanding; din_vld stalls.
  - All 16 checked, pass=1.
  - FIFO wraps at least 3 times.
- Responder returns only the first 10 results -> TIMEOUT after the last return; err_cnt=6, vec_cnt=10, done=1.
- Other cases:
  - Extra dout_vld while RUN with the FIFO empty -> err_cnt+1, unexp=1.
  - rst_in high mid-RUN -> all outputs 0 next cycle; a following start gives a clean run with pass=1.
